qspi_bus_arbiter: RTL and testbench

- Shares the single quad-SPI flash pin set (sclk, cs_n, io[3:0]) between two requesters.
  - Requester A: the MCU's flash interface.
  - Requester B: a UART-driven flash programmer/debug port.
- Grants whole chip-select transactions with round-robin fairness.
- Enforces a minimum deselect gap and an optional ownership watchdog.
- Sits between the requesters and the top-level tristate pads; the pad level consumes qdo/oe and supplies qdi.

---
 rtl/qspi_bus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_qspi_bus_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_bus_arbiter.sv
// Two-requester quad-SPI pin arbiter: whole-transaction grants, round-robin ties,
// enforced chip-select gap and optional ownership watchdog; all pad outputs registered.
module qspi_bus_arbiter #(
  parameter int TGAP = 4,
  parameter int TMAX = 0,
  parameter int TW   = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_cs_n,
  input  logic       a_sclk,
  input  logic [3:0] a_qdo,
  input  logic [3:0] a_oe,
  output logic       a_gnt,
  input  logic       b_cs_n,
  input  logic       b_sclk,
  input  logic [3:0] b_qdo,
  input  logic [3:0] b_oe,
  output logic       b_gnt,
  input  logic [3:0] qdi,
  output logic [3:0] a_qdi,
  output logic [3:0] b_qdi,
  output logic       spi_sclk,
  output logic       spi_csn,
  output logic [3:0] qdo,
  output logic [3:0] oe,
  output logic       abort
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN_A = 2'd1,
    S_OWN_B = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam int            WD_LIM   = (TMAX > 0) ? TMAX - 1 : 0;
  localparam logic [TW-1:0] WD_LAST  = TW'(WD_LIM);
  localparam logic [7:0]    GAP_LAST = 8'(TGAP - 1);

  state_t        state_q, state_d;
  logic          last_b_q, last_b_d;
  logic [7:0]    gap_cnt_q, gap_cnt_d;
  logic [TW-1:0] wd_cnt_q, wd_cnt_d;
  logic          a_blk_q, a_blk_d;
  logic          b_blk_q, b_blk_d;
  logic          abort_q, abort_d;
  logic          a_gnt_q, a_gnt_d;
  logic          b_gnt_q, b_gnt_d;
  logic          csn_q, csn_d;
  logic          sclk_q, sclk_d;
  logic [3:0]    qdo_q, qdo_d;
  logic [3:0]    oe_q, oe_d;

  logic          a_req, b_req;
  logic          own_cs_n, own_sclk;
  logic [3:0]    own_qdo, own_oe;
  logic          wd_hit;

  // A requester blocked by the watchdog stays invisible until its cs_n is seen high.
  assign a_req = ~a_cs_n & ~a_blk_q;
  assign b_req = ~b_cs_n & ~b_blk_q;

  assign own_cs_n = (state_q == S_OWN_B) ? b_cs_n : a_cs_n;
  assign own_sclk = (state_q == S_OWN_B) ? b_sclk : a_sclk;
  assign own_qdo  = (state_q == S_OWN_B) ? b_qdo  : a_qdo;
  assign own_oe   = (state_q == S_OWN_B) ? b_oe   : a_oe;

  assign wd_hit = (TMAX > 0) && (wd_cnt_q == WD_LAST);

  always_comb begin
    state_d   = state_q;
    last_b_d  = last_b_q;
    gap_cnt_d = gap_cnt_q;
    wd_cnt_d  = wd_cnt_q;
    a_blk_d   = a_blk_q & ~a_cs_n;
    b_blk_d   = b_blk_q & ~b_cs_n;
    abort_d   = abort_q;
    a_gnt_d   = a_gnt_q;
    b_gnt_d   = b_gnt_q;
    csn_d     = 1'b1;
    sclk_d    = 1'b0;
    qdo_d     = 4'h0;
    oe_d      = 4'h0;

    case (state_q)
      S_IDLE: begin
        gap_cnt_d = 8'd0;
        wd_cnt_d  = '0;
        if (a_req && (!b_req || last_b_q)) begin
          state_d  = S_OWN_A;
          a_gnt_d  = 1'b1;
          last_b_d = 1'b0;
        end else if (b_req) begin
          state_d  = S_OWN_B;
          b_gnt_d  = 1'b1;
          last_b_d = 1'b1;
        end
      end

      S_OWN_A, S_OWN_B: begin
        if (own_cs_n || wd_hit) begin
          // Pads default to idle values above, so csn rises together with sclk low.
          state_d   = S_GAP;
          gap_cnt_d = 8'd0;
          a_gnt_d   = 1'b0;
          b_gnt_d   = 1'b0;
          if (!own_cs_n) begin
            abort_d = 1'b1;
            if (state_q == S_OWN_A) a_blk_d = 1'b1;
            else                    b_blk_d = 1'b1;
          end
        end else begin
          csn_d    = own_cs_n;
          sclk_d   = own_sclk;
          qdo_d    = own_qdo;
          oe_d     = own_oe;
          wd_cnt_d = wd_cnt_q + TW'(1);
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_b_q  <= 1'b1;
      gap_cnt_q <= 8'd0;
      wd_cnt_q  <= '0;
      a_blk_q   <= 1'b0;
      b_blk_q   <= 1'b0;
      abort_q   <= 1'b0;
      a_gnt_q   <= 1'b0;
      b_gnt_q   <= 1'b0;
      csn_q     <= 1'b1;
      sclk_q    <= 1'b0;
      qdo_q     <= 4'h0;
      oe_q      <= 4'h0;
    end else begin
      state_q   <= state_d;
      last_b_q  <= last_b_d;
      gap_cnt_q <= gap_cnt_d;
      wd_cnt_q  <= wd_cnt_d;
      a_blk_q   <= a_blk_d;
      b_blk_q   <= b_blk_d;
      abort_q   <= abort_d;
      a_gnt_q   <= a_gnt_d;
      b_gnt_q   <= b_gnt_d;
      csn_q     <= csn_d;
      sclk_q    <= sclk_d;
      qdo_q     <= qdo_d;
      oe_q      <= oe_d;
    end
  end

  assign a_gnt    = a_gnt_q;
  assign b_gnt    = b_gnt_q;
  assign abort    = abort_q;
  assign spi_csn  = csn_q;
  assign spi_sclk = sclk_q;
  assign qdo      = qdo_q;
  assign oe       = oe_q;

  // Non-owners see the flash idle pull-up pattern.
  assign a_qdi = a_gnt_q ? qdi : 4'hF;
  assign b_qdi = b_gnt_q ? qdi : 4'hF;

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Bench for qspi_bus_arbiter: transaction-level owner model checked every cycle,
// plus directed scenarios with hand-computed cycle counts.
module tb_qspi_bus_arbiter;
  localparam int TGAP = 4;
  localparam int TMAX = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_cs_n = 1'b1, a_sclk = 1'b0;
  logic [3:0] a_qdo = 4'h0, a_oe = 4'h0;
  logic       b_cs_n = 1'b1, b_sclk = 1'b0;
  logic [3:0] b_qdo = 4'h0, b_oe = 4'h0;
  logic [3:0] qdi = 4'h0;
  logic       a_gnt, b_gnt, spi_sclk, spi_csn, abort;
  logic [3:0] a_qdi, b_qdi, qdo, oe;

  qspi_bus_arbiter #(.TGAP(TGAP), .TMAX(TMAX), .TW(24)) dut (
    .clk(clk), .rst(rst),
    .a_cs_n(a_cs_n), .a_sclk(a_sclk), .a_qdo(a_qdo), .a_oe(a_oe), .a_gnt(a_gnt),
    .b_cs_n(b_cs_n), .b_sclk(b_sclk), .b_qdo(b_qdo), .b_oe(b_oe), .b_gnt(b_gnt),
    .qdi(qdi), .a_qdi(a_qdi), .b_qdi(b_qdi),
    .spi_sclk(spi_sclk), .spi_csn(spi_csn), .qdo(qdo), .oe(oe), .abort(abort)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the bus, how long the gap still runs, who spoke last.
  int         m_owner;      // 0 none, 1 A, 2 B
  int         m_gap;        // gap cycles still to serve
  int         m_held;       // cycles the current owner has held the bus
  bit         m_last_a;
  bit         m_blk_a, m_blk_b, m_abort;
  bit         m_csn, m_sclk;
  logic [3:0] m_qdo, m_oe;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    bit ra, rb, ocs;
    if (rst) begin
      m_owner = 0; m_gap = 0; m_held = 0; m_last_a = 1'b0;
      m_blk_a = 1'b0; m_blk_b = 1'b0; m_abort = 1'b0;
      m_csn = 1'b1; m_sclk = 1'b0; m_qdo = 4'h0; m_oe = 4'h0;
      m_valid = 1'b1;
    end else begin
      ra = !a_cs_n && !m_blk_a;
      rb = !b_cs_n && !m_blk_b;
      if (a_cs_n) m_blk_a = 1'b0;
      if (b_cs_n) m_blk_b = 1'b0;
      m_csn = 1'b1; m_sclk = 1'b0; m_qdo = 4'h0; m_oe = 4'h0;
      if (m_owner != 0) begin
        ocs = (m_owner == 1) ? a_cs_n : b_cs_n;
        if (ocs || m_held + 1 >= TMAX) begin
          if (!ocs) begin
            m_abort = 1'b1;
            if (m_owner == 1) m_blk_a = 1'b1; else m_blk_b = 1'b1;
          end
          m_owner = 0;
          m_gap = TGAP;
        end else begin
          m_csn  = 1'b0;
          m_sclk = (m_owner == 1) ? a_sclk : b_sclk;
          m_qdo  = (m_owner == 1) ? a_qdo : b_qdo;
          m_oe   = (m_owner == 1) ? a_oe : b_oe;
          m_held++;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else begin
        if (ra && rb) m_owner = m_last_a ? 2 : 1;
        else if (ra)  m_owner = 1;
        else if (rb)  m_owner = 2;
        if (m_owner != 0) begin
          m_last_a = (m_owner == 1);
          m_held = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_a_gnt",   a_gnt,    m_owner == 1);
      chk("cyc_b_gnt",   b_gnt,    m_owner == 2);
      chk("cyc_spi_csn", spi_csn,  m_csn);
      chk("cyc_spi_sclk", spi_sclk, m_sclk);
      chk("cyc_qdo",     qdo,      m_qdo);
      chk("cyc_oe",      oe,       m_oe);
      chk("cyc_abort",   abort,    m_abort);
      chk("cyc_a_qdi",   a_qdi,    (m_owner == 1) ? qdi : 4'hF);
      chk("cyc_b_qdi",   b_qdi,    (m_owner == 2) ? qdi : 4'hF);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until the named grant rises; returns the number of steps taken (or -1).
  task automatic wait_gnt(input bit want_b, input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      step();
      if ((want_b ? b_gnt : a_gnt) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_cs_n = 1'b1; a_sclk = 1'b0; a_qdo = 4'h0; a_oe = 4'h0;
    b_cs_n = 1'b1; b_sclk = 1'b0; b_qdo = 4'h0; b_oe = 4'h0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not end, expected finish");
    $fatal(1);
  end

  initial begin
    int n, cs_hi;

    // Reset state
    do_reset();
    chk("rst_spi_csn", spi_csn, 1'b1);
    chk("rst_gnts", {a_gnt, b_gnt}, 2'b00);
    chk("rst_oe", oe, 4'h0);
    chk("rst_abort", abort, 1'b0);

    // A alone: grant next cycle, csn one cycle later, sclk copied with 1-cycle delay
    a_cs_n = 1'b0;
    step();
    chk("a_gnt_rise", a_gnt, 1'b1);
    chk("a_csn_still_hi", spi_csn, 1'b1);
    step();
    chk("a_csn_low", spi_csn, 1'b0);
    a_sclk = 1'b1; a_qdo = 4'h5; a_oe = 4'hF; qdi = 4'h3;
    b_cs_n = 1'b0; b_sclk = 1'b1; b_qdo = 4'hA; b_oe = 4'hF;
    #1;
    chk("a_qdi_pass", a_qdi, 4'h3);
    chk("b_qdi_idle", b_qdi, 4'hF);
    step();
    chk("a_sclk_fwd", spi_sclk, 1'b1);
    chk("a_qdo_fwd", qdo, 4'h5);
    chk("b_no_gnt", b_gnt, 1'b0);
    for (int i = 0; i < 8; i++) begin
      a_sclk = i[0]; b_sclk = ~i[0]; b_qdo = 4'(i); a_qdo = 4'(i + 3); qdi = 4'(i * 5);
      step();
    end

    // A releases with B pending: gap then B
    a_cs_n = 1'b1; a_sclk = 1'b0; a_oe = 4'h0;
    step();
    chk("rel_a_gnt", a_gnt, 1'b0);
    chk("rel_csn", spi_csn, 1'b1);
    chk("rel_sclk", spi_sclk, 1'b0);
    cs_hi = 1;
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (spi_csn) cs_hi++;
      if (b_gnt) begin n = i; break; end
    end
    chk("gap_to_b_gnt", n, 5);
    b_sclk = 1'b0;
    step();
    chk("b_csn_hi_cycles", cs_hi, 6);
    chk("b_oe_drive", oe, 4'hF);
    b_cs_n = 1'b1; b_oe = 4'h0;
    repeat (7) step();

    // Tie after reset goes to A, next tie goes to B
    do_reset();
    a_cs_n = 1'b0; b_cs_n = 1'b0;
    step();
    chk("tie1_gnt", {a_gnt, b_gnt}, 2'b10);
    repeat (3) step();
    a_cs_n = 1'b1; b_cs_n = 1'b1;
    step();
    a_cs_n = 1'b0; b_cs_n = 1'b0;
    wait_gnt(1'b1, 20, n);
    chk("tie2_delay", n, 5);
    chk("tie2_gnt", {a_gnt, b_gnt}, 2'b01);
    repeat (3) step();
    b_cs_n = 1'b1;
    step();
    wait_gnt(1'b0, 20, n);
    chk("a_after_b", n, 5);
    repeat (2) step();
    a_cs_n = 1'b1;
    repeat (7) step();

    // Watchdog: A never releases; B waits, then A blocked until it releases once
    a_cs_n = 1'b0; a_oe = 4'hF; a_qdo = 4'h6;
    step();
    chk("wd_a_gnt", a_gnt, 1'b1);
    n = 1;
    for (int i = 0; i < 200; i++) begin
      if (i == 50) b_cs_n = 1'b0;
      step();
      if (!a_gnt) break;
      n++;
    end
    chk("wd_hold_cycles", n, 100);
    chk("wd_abort", abort, 1'b1);
    chk("wd_csn", spi_csn, 1'b1);
    chk("wd_oe", oe, 4'h0);
    wait_gnt(1'b1, 20, n);
    chk("wd_b_after_gap", n, 5);
    repeat (3) step();
    b_cs_n = 1'b1;
    repeat (12) step();
    chk("wd_a_blocked", a_gnt, 1'b0);
    a_cs_n = 1'b1;
    step();
    a_cs_n = 1'b0;
    wait_gnt(1'b0, 5, n);
    chk("wd_a_regrant", n, 1);
    chk("wd_abort_sticky", abort, 1'b1);

    // Reset mid-transaction with pads active
    repeat (2) step();
    chk("mid_oe_active", oe, 4'hF);
    rst = 1'b1;
    step();
    chk("mid_rst_csn", spi_csn, 1'b1);
    chk("mid_rst_oe", oe, 4'h0);
    chk("mid_rst_qdo", qdo, 4'h0);
    chk("mid_rst_gnts", {a_gnt, b_gnt}, 2'b00);
    chk("mid_rst_abort", abort, 1'b0);
    rst = 1'b0;
    step();
    chk("post_rst_a_gnt", a_gnt, 1'b1);
    repeat (3) step();
    a_cs_n = 1'b1; a_oe = 4'h0;
    repeat (7) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
